// File: rtl/param_register_bank.sv
// param_register_bank: holds the active parameter set for the frame renderer.
// Words arrive over a VALID/READY byte interface: NUM_REGS parameter words
// followed by one repeat-count word. NEXT pulses count the set down; FINISH
// marks expiry.
// Optional feature macro: PARAM_SHADOW_EN (double-buffered loading while running).
module param_register_bank #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                       ACLK,
    input  logic                       RESET,
    input  logic [DATA_W-1:0]          DIN,
    input  logic                       VALID,
    output logic                       READY,
    input  logic                       NEXT,
    output logic                       FINISH_READ,
    output logic                       FINISH,
    output logic                       RUNNING,
    output logic [NUM_REGS*DATA_W-1:0] PARAMS,
    output logic [DATA_W-1:0]          COUNT
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [DATA_W-1:0] CNT_ONE  = DATA_W'(1);

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t                           state_reg, state_next;
    logic [IDX_W-1:0]                 idx_reg, idx_next;
    logic [NUM_REGS-1:0][DATA_W-1:0]  params_reg, params_next;
    logic [DATA_W-1:0]                count_reg, count_next;
    logic                             ready_reg, ready_next;
    logic                             finish_read_reg, finish_read_next;
    logic                             finish_reg, finish_next;
    logic                             running_reg, running_next;

    logic accept;
    assign accept = VALID && ready_reg;

`ifdef PARAM_SHADOW_EN
    logic [NUM_REGS-1:0][DATA_W-1:0]  shadow_params_reg, shadow_params_next;
    logic [DATA_W-1:0]                shadow_count_reg, shadow_count_next;
    logic                             shadow_full_reg, shadow_full_next;
    // FINISH_READ that collided with a FINISH pulse is deferred one cycle
    logic                             fr_pend_reg, fr_pend_next;
    logic                             complete;
    logic                             fr_set;

    // Shadow bank registers
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            shadow_params_reg <= '0;
            shadow_count_reg  <= '0;
            shadow_full_reg   <= 1'b0;
            fr_pend_reg       <= 1'b0;
        end else begin
            shadow_params_reg <= shadow_params_next;
            shadow_count_reg  <= shadow_count_next;
            shadow_full_reg   <= shadow_full_next;
            fr_pend_reg       <= fr_pend_next;
        end
    end

    // Next-state logic: words fill the shadow, completed sets move to active
    always_comb begin
        state_next         = state_reg;
        idx_next           = idx_reg;
        params_next        = params_reg;
        count_next         = count_reg;
        finish_read_next   = 1'b0;
        finish_next        = 1'b0;
        shadow_params_next = shadow_params_reg;
        shadow_count_next  = shadow_count_reg;
        shadow_full_next   = shadow_full_reg;
        fr_set             = 1'b0;
        complete           = accept && (idx_reg == LAST_IDX);

        if (accept) begin
            if (idx_reg == LAST_IDX) begin
                shadow_count_next = DIN;
                idx_next          = '0;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_reg == IDX_W'(i)) shadow_params_next[i] = DIN;
                end
                idx_next = idx_reg + IDX_ONE;
            end
        end

        case (state_reg)
            LOAD: begin
                if (complete) begin
                    params_next      = shadow_params_next;
                    count_next       = shadow_count_next;
                    finish_read_next = 1'b1;
                    state_next       = RUN;
                end
            end
            RUN: begin
                if (NEXT && (count_reg > CNT_ONE)) begin
                    count_next = count_reg - CNT_ONE;
                end else if (NEXT) begin
                    finish_next = 1'b1;
                    if (shadow_full_reg || complete) begin
                        // Seamless switch to the buffered set
                        params_next      = shadow_params_next;
                        count_next       = shadow_count_next;
                        shadow_full_next = 1'b0;
                        fr_set           = complete;
                    end else begin
                        count_next = '0;
                        state_next = LOAD;
                    end
                end else if (complete) begin
                    shadow_full_next = 1'b1;
                    finish_read_next = 1'b1;
                end
            end
            default: state_next = LOAD;
        endcase

        finish_read_next = finish_read_next || (fr_pend_reg && !finish_next);
        fr_pend_next     = fr_set || (fr_pend_reg && finish_next);
        ready_next       = !shadow_full_next;
        running_next     = (state_next == RUN);
    end
`else
    // Next-state logic: words go straight into the active set
    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        params_next      = params_reg;
        count_next       = count_reg;
        finish_read_next = 1'b0;
        finish_next      = 1'b0;

        case (state_reg)
            LOAD: begin
                if (accept) begin
                    if (idx_reg == LAST_IDX) begin
                        count_next       = DIN;
                        idx_next         = '0;
                        finish_read_next = 1'b1;
                        state_next       = RUN;
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (idx_reg == IDX_W'(i)) params_next[i] = DIN;
                        end
                        idx_next = idx_reg + IDX_ONE;
                    end
                end
            end
            RUN: begin
                if (NEXT) begin
                    if (count_reg > CNT_ONE) begin
                        count_next = count_reg - CNT_ONE;
                    end else begin
                        // A loaded count of 0 expires like 1; never wraps
                        count_next  = '0;
                        finish_next = 1'b1;
                        state_next  = LOAD;
                        idx_next    = '0;
                    end
                end
            end
            default: state_next = LOAD;
        endcase

        ready_next   = (state_next == LOAD);
        running_next = (state_next == RUN);
    end
`endif

    // Main state and output registers
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            state_reg       <= LOAD;
            idx_reg         <= '0;
            params_reg      <= '0;
            count_reg       <= '0;
            ready_reg       <= 1'b0;
            finish_read_reg <= 1'b0;
            finish_reg      <= 1'b0;
            running_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            params_reg      <= params_next;
            count_reg       <= count_next;
            ready_reg       <= ready_next;
            finish_read_reg <= finish_read_next;
            finish_reg      <= finish_next;
            running_reg     <= running_next;
        end
    end

    assign READY       = ready_reg;
    assign FINISH_READ = finish_read_reg;
    assign FINISH      = finish_reg;
    assign RUNNING     = running_reg;
    assign PARAMS      = params_reg;
    assign COUNT       = count_reg;

endmodule

// File: tb/tb_param_register_bank.sv
// Directed testbench for param_register_bank (DATA_W=8, NUM_REGS=4).
module tb_param_register_bank;

    logic        ACLK;
    logic        RESET;
    logic [7:0]  DIN;
    logic        VALID;
    logic        READY;
    logic        NEXT;
    logic        FINISH_READ;
    logic        FINISH;
    logic        RUNNING;
    logic [31:0] PARAMS;
    logic [7:0]  COUNT;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef PARAM_SHADOW_EN
    localparam logic RUN_READY = 1'b1;
    localparam logic [31:0] T4_PARTIAL = 32'hA4A3A2A1;
    localparam logic [31:0] T5_PARTIAL = 32'h04030201;
`else
    localparam logic RUN_READY = 1'b0;
    localparam logic [31:0] T4_PARTIAL = 32'h04030201;
    localparam logic [31:0] T5_PARTIAL = 32'h04036655;
`endif

    param_register_bank #(.DATA_W(8), .NUM_REGS(4)) dut (
        .ACLK        (ACLK),
        .RESET       (RESET),
        .DIN         (DIN),
        .VALID       (VALID),
        .READY       (READY),
        .NEXT        (NEXT),
        .FINISH_READ (FINISH_READ),
        .FINISH      (FINISH),
        .RUNNING     (RUNNING),
        .PARAMS      (PARAMS),
        .COUNT       (COUNT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Present a word and hold VALID until it is accepted (bounded wait)
    task automatic send_word(input logic [7:0] d);
        logic rdy;
        int   waited;
        DIN    = d;
        VALID  = 1'b1;
        waited = 0;
        do begin
            rdy = READY;
            tick();
            waited++;
        end while (!rdy && waited < 20);
        if (!rdy) check("send_timeout", 32'd0, 32'd1);
        $display("word 0x%02h sent: PARAMS=0x%08h COUNT=%0d", d, PARAMS, COUNT);
    endtask

    task automatic pulse_next();
        NEXT = 1'b1;
        tick();
        NEXT = 1'b0;
        $display("NEXT: COUNT=%0d FINISH=%0b RUNNING=%0b", COUNT, FINISH, RUNNING);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w4 [0:3];
        w4[0] = 8'h01; w4[1] = 8'h02; w4[2] = 8'h03; w4[3] = 8'h04;
        RESET = 1'b1; VALID = 1'b0; NEXT = 1'b0; DIN = 8'h00;
        tick(); tick();
        RESET = 1'b0;
        check("rst_params", PARAMS, 32'h0);
        check("rst_count", {24'h0, COUNT}, 32'h0);
        check("rst_ready", {31'h0, READY}, 32'h0);
        check("rst_running", {31'h0, RUNNING}, 32'h0);
        check("rst_flags", {30'h0, FINISH, FINISH_READ}, 32'h0);

        // Test 1: stream a full set with VALID held high
        send_word(8'h10); send_word(8'h20); send_word(8'h30); send_word(8'h40);
        send_word(8'h03);
        VALID = 1'b0;
        check("t1_params", PARAMS, 32'h40302010);
        check("t1_count", {24'h0, COUNT}, 32'd3);
        check("t1_finish_read", {31'h0, FINISH_READ}, 32'd1);
        check("t1_running", {31'h0, RUNNING}, 32'd1);
        check("t1_ready", {31'h0, READY}, {31'h0, RUN_READY});
        tick();
        check("t1_fr_pulse_end", {31'h0, FINISH_READ}, 32'd0);

        // Test 2: three spaced NEXT pulses
        pulse_next();
        check("t2_count2", {24'h0, COUNT}, 32'd2);
        check("t2_nofinish1", {31'h0, FINISH}, 32'd0);
        repeat (4) tick();
        pulse_next();
        check("t2_count1", {24'h0, COUNT}, 32'd1);
        check("t2_nofinish2", {31'h0, FINISH}, 32'd0);
        repeat (4) tick();
        pulse_next();
        check("t2_count0", {24'h0, COUNT}, 32'd0);
        check("t2_finish", {31'h0, FINISH}, 32'd1);
        check("t2_running", {31'h0, RUNNING}, 32'd0);
        check("t2_ready", {31'h0, READY}, 32'd1);
        check("t2_params_kept", PARAMS, 32'h40302010);
        tick();
        check("t2_finish_end", {31'h0, FINISH}, 32'd0);

        // Test 3: count of zero expires after one NEXT, no wrap
        send_word(8'hA1); send_word(8'hA2); send_word(8'hA3); send_word(8'hA4);
        send_word(8'h00);
        VALID = 1'b0;
        check("t3_params", PARAMS, 32'hA4A3A2A1);
        check("t3_count", {24'h0, COUNT}, 32'd0);
        check("t3_running", {31'h0, RUNNING}, 32'd1);
        pulse_next();
        check("t3_finish", {31'h0, FINISH}, 32'd1);
        check("t3_nowrap", {24'h0, COUNT}, 32'd0);
        check("t3_running_off", {31'h0, RUNNING}, 32'd0);

        // Test 4: VALID toggling with NEXT pulses during LOAD
        for (int i = 0; i < 4; i++) begin
            DIN = w4[i]; VALID = 1'b1; NEXT = 1'b0;
            tick();
            VALID = 1'b0; DIN = 8'hEE; NEXT = 1'b1;
            tick();
            NEXT = 1'b0;
            $display("toggle word 0x%02h: PARAMS=0x%08h COUNT=%0d", w4[i], PARAMS, COUNT);
        end
        check("t4_partial", PARAMS, T4_PARTIAL);
        check("t4_count_unchanged", {24'h0, COUNT}, 32'd0);
        check("t4_still_load", {31'h0, RUNNING}, 32'd0);
        DIN = 8'h05; VALID = 1'b1;
        tick();
        VALID = 1'b0;
        check("t4_params", PARAMS, 32'h04030201);
        check("t4_count", {24'h0, COUNT}, 32'd5);
        check("t4_finish_read", {31'h0, FINISH_READ}, 32'd1);
        // Back-to-back NEXT pulses each decrement
        NEXT = 1'b1; tick(); tick(); NEXT = 1'b0;
        check("t4_b2b_count", {24'h0, COUNT}, 32'd3);
        check("t4_b2b_nofinish", {31'h0, FINISH}, 32'd0);
        NEXT = 1'b1; tick(); tick(); tick(); NEXT = 1'b0;
        check("t4_finish", {31'h0, FINISH}, 32'd1);
        check("t4_count0", {24'h0, COUNT}, 32'd0);
        check("t4_fr_exclusive", {31'h0, FINISH_READ}, 32'd0);

        // Test 5: asynchronous reset mid-load
        send_word(8'h55); send_word(8'h66);
        VALID = 1'b0;
        check("t5_partial", PARAMS, T5_PARTIAL);
        #3;
        RESET = 1'b1;
        #1;
        check("t5_rst_params", PARAMS, 32'h0);
        check("t5_rst_count", {24'h0, COUNT}, 32'h0);
        check("t5_rst_outs", {28'h0, READY, RUNNING, FINISH, FINISH_READ}, 32'h0);
        tick();
        RESET = 1'b0;
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        send_word(8'h02);
        VALID = 1'b0;
        check("t5_params", PARAMS, 32'h44332211);
        check("t5_count", {24'h0, COUNT}, 32'd2);
        pulse_next();
        check("t5_count1", {24'h0, COUNT}, 32'd1);
        pulse_next();
        check("t5_finish", {31'h0, FINISH}, 32'd1);

`ifdef PARAM_SHADOW_EN
        // Test 6: seamless switch from set A to set B
        send_word(8'hA1); send_word(8'hA2); send_word(8'hA3); send_word(8'hA4);
        send_word(8'h02);
        VALID = 1'b0;
        check("t6_params_a", PARAMS, 32'hA4A3A2A1);
        check("t6_ready_run", {31'h0, READY}, 32'd1);
        send_word(8'hB1); send_word(8'hB2); send_word(8'hB3); send_word(8'hB4);
        send_word(8'h01);
        VALID = 1'b0;
        check("t6_fr_shadow", {31'h0, FINISH_READ}, 32'd1);
        check("t6_ready_full", {31'h0, READY}, 32'd0);
        check("t6_params_still_a", PARAMS, 32'hA4A3A2A1);
        pulse_next();
        check("t6_count1", {24'h0, COUNT}, 32'd1);
        check("t6_ready_full2", {31'h0, READY}, 32'd0);
        pulse_next();
        check("t6_finish", {31'h0, FINISH}, 32'd1);
        check("t6_params_b", PARAMS, 32'hB4B3B2B1);
        check("t6_count_b", {24'h0, COUNT}, 32'd1);
        check("t6_running", {31'h0, RUNNING}, 32'd1);
        check("t6_ready_free", {31'h0, READY}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_register_bank.md
Name: param_register_bank

Overview:
- Parametrised successor of the video-parameter register block.
- Receives a stream of NUM_REGS parameter words (e.g. X centre, Y centre, zoom, angle) plus one repeat-count word over a valid/ready byte interface.
- Holds those words as the active parameter set for the renderer, and counts down NEXT pulses (one per frame) until the set expires.
- Sits between the host byte receiver and the frame renderer.

Parameters:
- DATA_W, 8, width of each parameter word and of the repeat count.
- NUM_REGS, 4, number of parameter words per set; legal range 1..16. The count word follows the parameter words.

Ports:
- ACLK  input  1  clock
- RESET  input  1  asynchronous, active-high reset
- DIN  input  DATA_W  incoming word
- VALID  input  1  DIN valid
- READY  output  1  block can accept DIN this cycle
- NEXT  input  1  one-cycle pulse per consumed frame
- FINISH_READ  output  1  one-cycle pulse: full set (params + count) received
- FINISH  output  1  one-cycle pulse: repeat count exhausted
- RUNNING  output  1  high in RUN state
- PARAMS  output  NUM_REGS*DATA_W  active set; word i at bits [i*DATA_W +: DATA_W]
- COUNT  output  DATA_W  remaining repeat count

Behaviour:
- Reset (asynchronous, any state):
  - PARAMS = 0, COUNT = 0, word index = 0.
  - READY = 0, FINISH_READ = 0, FINISH = 0, RUNNING = 0.
  - State = LOAD; READY rises on the first clock after RESET deasserts.
- Transfer rule: a word is accepted on a rising ACLK edge where VALID && READY. VALID without READY is ignored; no data is lost or duplicated. DIN may change freely while VALID = 0.
- All outputs are registered.
- States: LOAD, RUN.
- LOAD:
  - READY = 1.
  - Accepted word with index < NUM_REGS is written to PARAMS word [index]; index increments.
  - Accepted word with index == NUM_REGS is written to COUNT; index returns to 0.
  - On the count word: FINISH_READ pulses for exactly one cycle (the cycle after acceptance), and the state moves to RUN on the same edge.
  - NEXT is ignored in LOAD.
- RUN:
  - READY = 0 (without the optional feature).
  - NEXT = 1 and COUNT > 1: COUNT decrements by 1.
  - NEXT = 1 and COUNT is 1 or 0: COUNT becomes 0, FINISH pulses one cycle, state returns to LOAD, index = 0.
  - A loaded count of 0 therefore behaves as 1; there is no wrap to 2^DATA_W-1.
  - PARAMS stay stable throughout RUN.
- Back-to-back NEXT pulses on consecutive cycles each decrement COUNT; no cycle is required between them.
- FINISH and FINISH_READ are never high in the same cycle.
- Latency:
  - Last word accepted at edge k → FINISH_READ high and RUNNING high in cycle k+1.
  - NEXT sampled at edge k → COUNT/FINISH updated in cycle k+1.

Optional Feature:
- Macro: PARAM_SHADOW_EN.
- Defined:
  - A shadow bank (NUM_REGS words + count) plus a shadow-full flag is added.
  - All accepted words go to the shadow bank. READY = !shadow_full, in both LOAD and RUN.
  - Shadow complete while in LOAD: the whole shadow bank is copied to PARAMS/COUNT in one edge, FINISH_READ pulses, state = RUN. PARAMS never show a partially written set.
  - Shadow complete while in RUN: shadow_full = 1 and FINISH_READ pulses; active PARAMS are untouched.
  - At the FINISH edge with shadow_full = 1: shadow is copied to active, shadow_full clears, FINISH pulses, and the state stays RUN (seamless switch, zero idle frames).
  - At the FINISH edge with shadow_full = 0: state returns to LOAD.
- Not defined:
  - Shadow logic is absent; behaviour is exactly as in the Behaviour section.
  - In LOAD, PARAMS update word by word as each word is accepted.

Test Plan:
1. Reset, then stream 0x10,0x20,0x30,0x40,0x03 with VALID held high → PARAMS = 0x40302010, COUNT = 3, one FINISH_READ pulse, RUNNING = 1, READY = 0.
2. From test 1, three NEXT pulses spaced 5 cycles apart → COUNT goes 2, 1, 0; FINISH pulses only after the third; state LOAD; READY = 1.
3. Load count 0x00, then one NEXT → FINISH after that single NEXT; COUNT stays 0 (no wrap to 0xFF).
4. VALID toggling every other cycle, plus NEXT pulses during LOAD → all five words captured in order; COUNT and state unaffected by NEXT.
5. Assert RESET after the second word of a load → all outputs 0 immediately; next load starts at word index 0.
6. PARAM_SHADOW_EN defined: load set A with count 2, load set B during RUN, then two NEXT pulses → PARAMS switch A→B on the FINISH edge, RUNNING stays 1, and READY stays low while the shadow is full.
